// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: fixed-priority arbitration of effect requests with preemption,
// one pending slot per effect, pause/flush, and note sequencing into the tone generator.
module sfx_scheduler #(
    parameter int unsigned TICK_CYCLES = 5_000_000,
    parameter int unsigned GAP_CYCLES  = 2_000_000,
    parameter logic [2:0]  VOLUME      = 3'd4,
    parameter logic [21:0] DIV_MUTE    = 22'h3FFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        pause,
    input  logic        flush,
    output logic [21:0] note_div,
    output logic [2:0]  volume,
    output logic        busy,
    output logic [1:0]  active_id,
    output logic        done,
    output logic [1:0]  done_id
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

    localparam logic [22:0] TICK_LAST = 23'(TICK_CYCLES - 1);
    localparam logic [22:0] GAP_LAST  = 23'(GAP_CYCLES - 1);

    state_t      state;
    logic [3:0]  pend;
    logic [22:0] cyc;
    logic [4:0]  unit_cnt;
    logic        step;

    logic [3:0]  eff;
    logic [1:0]  grant_id;
    logic [1:0]  restart_id;
    logic        preempt;
    logic        tick_end;
    logic        unit_end;
    logic        gap_end;

    // IDs: 0 BEEP, 1 GO, 2 P1_CP, 3 P2_CP
    function automatic logic [21:0] step_div(input logic [1:0] id, input logic s);
        case ({id, s})
            3'b000, 3'b001: step_div = 22'd113_636;
            3'b010, 3'b011: step_div = 22'd56_818;
            3'b100:         step_div = 22'd170_068;
            3'b101:         step_div = 22'd113_636;
            3'b110:         step_div = 22'd190_840;
            3'b111:         step_div = 22'd127_551;
            default:        step_div = DIV_MUTE;
        endcase
    endfunction

    function automatic logic [4:0] step_units(input logic [1:0] id);
        case (id)
            2'd0:    step_units = 5'd3;
            2'd1:    step_units = 5'd20;
            default: step_units = 5'd10;
        endcase
    endfunction

    // Single-step effects (BEEP, GO) end after step 0.
    function automatic logic is_last_step(input logic [1:0] id, input logic s);
        is_last_step = (id[1] == 1'b0) ? 1'b1 : s;
    endfunction

    // IDs that outrank the given one (GO > BEEP > P1_CP > P2_CP).
    function automatic logic [3:0] higher_mask(input logic [1:0] id);
        case (id)
            2'd1:    higher_mask = 4'b0000;
            2'd0:    higher_mask = 4'b0010;
            2'd2:    higher_mask = 4'b0011;
            2'd3:    higher_mask = 4'b0111;
            default: higher_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [1:0] pick_id(input logic [3:0] e);
        if (e[1])      pick_id = 2'd1;
        else if (e[0]) pick_id = 2'd0;
        else if (e[2]) pick_id = 2'd2;
        else           pick_id = 2'd3;
    endfunction

    function automatic logic [3:0] id_mask(input logic [1:0] id);
        id_mask = 4'b0001 << id;
    endfunction

    // Arbitration and terminal-count decode
    always_comb begin
        eff        = pend | req;
        grant_id   = pick_id(eff);
        preempt    = |(eff & higher_mask(active_id));
        restart_id = preempt ? grant_id : active_id;
        tick_end   = (cyc == TICK_LAST);
        unit_end   = (unit_cnt == (step_units(active_id) - 5'd1));
        gap_end    = (cyc == GAP_LAST);
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= 4'b0000;
            cyc       <= 23'd0;
            unit_cnt  <= 5'd0;
            step      <= 1'b0;
            note_div  <= DIV_MUTE;
            volume    <= 3'd0;
            busy      <= 1'b0;
            active_id <= 2'd0;
            done      <= 1'b0;
            done_id   <= 2'd0;
        end else if (flush) begin
            state    <= IDLE;
            pend     <= 4'b0000;
            cyc      <= 23'd0;
            unit_cnt <= 5'd0;
            step     <= 1'b0;
            note_div <= DIV_MUTE;
            volume   <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (pause) begin
            pend     <= eff;
            note_div <= DIV_MUTE;
            volume   <= 3'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|eff) begin
                        pend      <= eff & ~id_mask(grant_id);
                        active_id <= grant_id;
                        state     <= PLAY;
                        cyc       <= 23'd0;
                        unit_cnt  <= 5'd0;
                        step      <= 1'b0;
                        note_div  <= step_div(grant_id, 1'b0);
                        volume    <= VOLUME;
                        busy      <= 1'b1;
                    end else begin
                        pend     <= eff;
                        note_div <= DIV_MUTE;
                        volume   <= 3'd0;
                        busy     <= 1'b0;
                    end
                end
                PLAY: begin
                    busy <= 1'b1;
                    if (preempt || req[active_id]) begin
                        pend      <= eff & ~id_mask(restart_id);
                        active_id <= restart_id;
                        cyc       <= 23'd0;
                        unit_cnt  <= 5'd0;
                        step      <= 1'b0;
                        note_div  <= step_div(restart_id, 1'b0);
                        volume    <= VOLUME;
                    end else begin
                        pend     <= eff;
                        note_div <= step_div(active_id, step);
                        volume   <= VOLUME;
                        if (tick_end) begin
                            cyc <= 23'd0;
                            if (unit_end) begin
                                unit_cnt <= 5'd0;
                                if (is_last_step(active_id, step)) begin
                                    step     <= 1'b0;
                                    done     <= 1'b1;
                                    done_id  <= active_id;
                                    state    <= GAP;
                                    note_div <= DIV_MUTE;
                                    volume   <= 3'd0;
                                end else begin
                                    step     <= 1'b1;
                                    note_div <= step_div(active_id, 1'b1);
                                end
                            end else begin
                                unit_cnt <= unit_cnt + 5'd1;
                            end
                        end else begin
                            cyc <= cyc + 23'd1;
                        end
                    end
                end
                GAP: begin
                    pend     <= eff;
                    note_div <= DIV_MUTE;
                    volume   <= 3'd0;
                    if (gap_end) begin
                        cyc   <= 23'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cyc  <= cyc + 23'd1;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cyc      <= 23'd0;
                    unit_cnt <= 5'd0;
                    step     <= 1'b0;
                    note_div <= DIV_MUTE;
                    volume   <= 3'd0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: directed scenarios plus random traffic, every cycle compared
// against a remaining-time reference model of the effect sequencing rules.
module tb_sfx_scheduler;
    localparam int T = 4;
    localparam int G = 2;
    localparam logic [21:0] MUTE = 22'h3FFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic        pause = 1'b0;
    logic        flush = 1'b0;
    logic [21:0] note_div;
    logic [2:0]  volume;
    logic        busy;
    logic [1:0]  active_id;
    logic        done;
    logic [1:0]  done_id;

    sfx_scheduler #(.TICK_CYCLES(T), .GAP_CYCLES(G), .VOLUME(3'd4), .DIV_MUTE(MUTE)) dut (
        .clk(clk), .rst(rst), .req(req), .pause(pause), .flush(flush),
        .note_div(note_div), .volume(volume), .busy(busy), .active_id(active_id),
        .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: effect tables and "cycles left in this step" bookkeeping
    int div_tab[4][2]  = '{'{113636, 0}, '{56818, 0}, '{170068, 113636}, '{190840, 127551}};
    int unit_tab[4][2] = '{'{3, 0}, '{20, 0}, '{10, 10}, '{10, 10}};
    int nsteps[4]      = '{1, 1, 2, 2};
    int prio[4]        = '{1, 0, 2, 3};

    int         m_state;  // 0 idle, 1 play, 2 gap
    logic [3:0] m_pend;
    int         m_id, m_step, m_left, m_gap;
    logic [21:0] e_div;
    logic [2:0]  e_vol;
    logic        e_busy, e_done;
    logic [1:0]  e_aid, e_did;
    int          dq[$];

    function automatic int top_of(input logic [3:0] e);
        for (int i = 0; i < 4; i++) if (e[prio[i]]) return prio[i];
        return -1;
    endfunction

    function automatic int rank_of(input int id);
        for (int i = 0; i < 4; i++) if (prio[i] == id) return i;
        return 4;
    endfunction

    task automatic m_reset();
        m_state = 0; m_pend = 4'b0000; m_id = 0; m_step = 0; m_left = 0; m_gap = 0;
        e_div = MUTE; e_vol = 3'd0; e_busy = 1'b0; e_done = 1'b0; e_aid = 2'd0; e_did = 2'd0;
    endtask

    task automatic m_start(input int id);
        m_pend[id] = 1'b0;
        m_id = id; m_step = 0; m_left = unit_tab[id][0] * T; m_state = 1;
    endtask

    task automatic model_step(input logic [3:0] r, input logic p, input logic f);
        logic [3:0] eff;
        e_done = 1'b0;
        if (f) begin
            m_pend = 4'b0000; m_state = 0;
        end else if (p) begin
            m_pend = m_pend | r;
        end else begin
            eff = m_pend | r;
            m_pend = eff;
            case (m_state)
                0: if (eff != 4'b0000) m_start(top_of(eff));
                1: begin
                    if (eff != 4'b0000 && rank_of(top_of(eff)) < rank_of(m_id)) m_start(top_of(eff));
                    else if (r[m_id]) m_start(m_id);
                    else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_step + 1 < nsteps[m_id]) begin
                                m_step++;
                                m_left = unit_tab[m_id][m_step] * T;
                            end else begin
                                e_done = 1'b1; e_did = 2'(m_id); m_state = 2; m_gap = G;
                            end
                        end
                    end
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_state = 0;
                end
            endcase
        end
        e_busy = (m_state != 0);
        e_aid  = 2'(m_id);
        if (m_state == 1 && !p && !f) begin
            e_div = 22'(div_tab[m_id][m_step]); e_vol = 3'd4;
        end else begin
            e_div = MUTE; e_vol = 3'd0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare all outputs
    task automatic tick(input logic [3:0] r, input logic p, input logic f);
        req = r; pause = p; flush = f;
        @(posedge clk);
        model_step(r, p, f);
        #1;
        chk("note_div", 32'(note_div), 32'(e_div));
        chk("volume", 32'(volume), 32'(e_vol));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("active_id", 32'(active_id), 32'(e_aid));
        chk("done", 32'(done), 32'(e_done));
        chk("done_id", 32'(done_id), 32'(e_did));
        if (done) dq.push_back(int'(done_id));
        req = 4'b0000; flush = 1'b0;
    endtask

    int n_a, n_b, n_c;
    logic ps;

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_note_div", 32'(note_div), 32'(MUTE));
        chk("rst_volume", 32'(volume), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick(4'b0000, 1'b0, 1'b0);

        // 1: P1_CP alone
        dq.delete();
        tick(4'b0100, 1'b0, 1'b0);
        n_a = (note_div == 22'd170068) ? 1 : 0; n_b = 0;
        for (int i = 0; i < 90; i++) begin
            tick(4'b0000, 1'b0, 1'b0);
            if (note_div == 22'd170068) n_a++;
            if (note_div == 22'd113636) n_b++;
        end
        chk("t1_step0_cycles", 32'(n_a), 32'd40);
        chk("t1_step1_cycles", 32'(n_b), 32'd40);
        chk("t1_done_count", 32'(dq.size()), 32'd1);
        if (dq.size() > 0) chk("t1_done_id", 32'(dq[0]), 32'd2);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // 2: all four at once, played in priority order
        dq.delete();
        tick(4'b1111, 1'b0, 1'b0);
        chk("t2_first_div", 32'(note_div), 32'd56818);
        for (int i = 0; i < 320; i++) tick(4'b0000, 1'b0, 1'b0);
        chk("t2_done_count", 32'(dq.size()), 32'd4);
        if (dq.size() == 4) begin
            chk("t2_order0", 32'(dq[0]), 32'd1);
            chk("t2_order1", 32'(dq[1]), 32'd0);
            chk("t2_order2", 32'(dq[2]), 32'd2);
            chk("t2_order3", 32'(dq[3]), 32'd3);
        end

        // 3: GO preempts P2_CP in step 1
        dq.delete();
        tick(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 45; i++) tick(4'b0000, 1'b0, 1'b0);
        chk("t3_p2_step1", 32'(note_div), 32'd127551);
        tick(4'b0010, 1'b0, 1'b0);
        chk("t3_preempt_div", 32'(note_div), 32'd56818);
        chk("t3_preempt_id", 32'(active_id), 32'd1);
        for (int i = 0; i < 90; i++) tick(4'b0000, 1'b0, 1'b0);
        chk("t3_done_count", 32'(dq.size()), 32'd1);
        if (dq.size() > 0) chk("t3_done_id", 32'(dq[0]), 32'd1);

        // 4: lower-priority request waits for GO to finish
        dq.delete();
        tick(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(4'b0000, 1'b0, 1'b0);
        tick(4'b1000, 1'b0, 1'b0);
        chk("t4_go_continues", 32'(note_div), 32'd56818);
        for (int i = 0; i < 200; i++) tick(4'b0000, 1'b0, 1'b0);
        chk("t4_done_count", 32'(dq.size()), 32'd2);
        if (dq.size() == 2) begin
            chk("t4_first", 32'(dq[0]), 32'd1);
            chk("t4_second", 32'(dq[1]), 32'd3);
        end

        // 5: pause in the middle of BEEP after 6 sounding cycles
        dq.delete();
        tick(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(4'b0000, 1'b0, 1'b0);
        n_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000, 1'b1, 1'b0);
            if (note_div == MUTE && volume == 3'd0) n_a++;
        end
        chk("t5_muted_cycles", 32'(n_a), 32'd10);
        n_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000, 1'b0, 1'b0);
            if (note_div == 22'd113636 && dq.size() == 0) n_b++;
        end
        chk("t5_remaining", 32'(n_b), 32'd6);
        chk("t5_done_count", 32'(dq.size()), 32'd1);

        // 6a: asynchronous reset mid-PLAY
        tick(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(4'b0000, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_div", 32'(note_div), 32'(MUTE));
        chk("t6_async_vol", 32'(volume), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        m_reset();
        @(negedge clk) rst = 1'b0;
        tick(4'b0000, 1'b0, 1'b0);

        // 6b: flush with pending P1_CP; same-cycle requests dropped
        tick(4'b0001, 1'b0, 1'b0);
        tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0);
        tick(4'b1010, 1'b0, 1'b1);
        chk("t6_flush_busy", 32'(busy), 32'd0);
        n_c = 0;
        for (int i = 0; i < 100; i++) begin
            tick(4'b0000, 1'b0, 1'b0);
            if (volume != 3'd0) n_c++;
        end
        chk("t6_silent_after_flush", 32'(n_c), 32'd0);

        // Random traffic against the model
        ps = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) ps = ~ps;
            tick(($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                 ps, ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sound-effect scheduler that time-shares the single square-wave tone generator (note divider plus volume) among the race game's effect requesters: countdown beep, GO, P1 checkpoint and P2 checkpoint. It accepts one-cycle request pulses and arbitrates them by fixed priority, with preemption and one pending slot per effect. It sequences each effect's note list from an internal table and drives `note_div`/`volume` straight into the tone generator. It sits between the game state/flag logic and the tone generator, replacing ad-hoc per-effect counters.

## Interface
- `TICK_CYCLES`, 5_000_000 — clk cycles per duration unit (50 ms at 100 MHz).
- `GAP_CYCLES`, 2_000_000 — muted cycles inserted after every naturally completed effect.
- `VOLUME`, 3'd4 — volume driven while a note sounds.
- `DIV_MUTE`, 22'h3FFFFF — divider driven when silent.

- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  one-cycle request pulses: [0] BEEP, [1] GO, [2] P1_CP, [3] P2_CP.
- `pause`  in  1  level; freezes sequencing and mutes the output.
- `flush`  in  1  one-cycle pulse; drops the playing effect and all pending requests.
- `note_div`  out  22  divider to the tone generator (registered).
- `volume`  out  3  volume to the tone generator (registered).
- `busy`  out  1  high in PLAY or GAP.
- `active_id`  out  2  ID of the effect being played; holds its last value when idle.
- `done`  out  1  one-cycle pulse when an effect completes naturally.
- `done_id`  out  2  ID of the completed effect; valid with `done`.

## Operation
- Effect table, as (divider, units) steps:
  - BEEP: (113_636, 3).
  - GO: (56_818, 20).
  - P1_CP: (170_068, 10), (113_636, 10).
  - P2_CP: (190_840, 10), (127_551, 10).
- Priority, highest first: GO > BEEP > P1_CP > P2_CP.
- Pending register `pend[3:0]`.
  - A `req` bit sets the matching `pend` bit.
  - The bit clears when that effect is granted.
  - Repeated requests for an already-pending ID coalesce.
- Effective request set is `eff = pend | req`.
- States: IDLE, PLAY, GAP.
- IDLE: if `eff` is non-zero, grant the highest-priority ID, load step 0, go to PLAY.
- PLAY:
  - Count `TICK_CYCLES` per unit; at the end of a step's units, advance to the next step.
  - After the last step: pulse `done`/`done_id`, go to GAP.
  - If `eff` contains an ID of strictly higher priority than `active_id`: abort the current effect without `done`, grant the new ID, and restart at its step 0 with counters cleared.
  - A `req` for the same ID as `active_id` restarts that effect at step 0.
  - A lower-priority `req` only sets `pend`.
- GAP: output muted for `GAP_CYCLES`, then return to IDLE. Higher-priority preemption does not apply in GAP; requests only accumulate in `pend`.
- Pause:
  - While `pause=1`, all counters and the state register hold, and the outputs are `DIV_MUTE`/0.
  - `req` bits are still latched into `pend`.
  - When pause is released, the interrupted note resumes with its remaining count.
- Flush:
  - Clears `pend` and enters IDLE with muted output.
  - `req` bits arriving in the same cycle as `flush` are dropped.
  - `flush` takes precedence over `pause`.
- Outputs:
  - In PLAY (not paused): the current step's divider and `VOLUME`.
  - In all other cases: `DIV_MUTE` and 0.
- Counters:
  - Cycle counter is 23 bits, counting 0..`TICK_CYCLES`-1.
  - Unit counter is 5 bits.
  - Step index is 1 bit.
  - No counter wraps silently; every counter is reloaded at its terminal count.

## Timing
- Reset values: `note_div`=`DIV_MUTE`, `volume`=0, `busy`=0, `active_id`=0, `done`=0, `done_id`=0, `pend`=0, state IDLE, all counters 0.
- Grant latency: a `req` sampled at edge E while in IDLE means the outputs show step 0 immediately after E. This is 1 cycle.
- Preemption latency is the same single cycle.
- A step of N units occupies exactly N·`TICK_CYCLES` cycles of sounding output.
- `done` is asserted in the cycle after the last sounding cycle, together with entry to GAP.
- Simultaneous `req` bits in IDLE: the highest-priority bit is granted; the others remain in `pend`.
- A `pause` rise at edge E mutes the outputs from E+1.

## Test plan
Bench parameters: `TICK_CYCLES`=4, `GAP_CYCLES`=2.
1. `req`=4'b0100 in IDLE → `note_div`=170_068 for 40 cycles, then 113_636 for 40 cycles, then a `done` pulse with `done_id`=2, then 2 muted cycles, then `busy`=0.
2. `req`=4'b1111 in one cycle → GO plays first (56_818, 80 cycles), then BEEP, then P1_CP, then P2_CP, each separated by a 2-cycle gap, with 4 `done` pulses carrying IDs 1, 0, 2, 3.
3. P2_CP playing at step 1; `req[1]` pulse → next cycle `note_div`=56_818 and `active_id`=1; no `done` for ID 3.
4. GO playing; `req[3]` pulse → GO completes uninterrupted, then P2_CP plays after the gap.
5. BEEP at unit 1, cycle 2; hold `pause` for 10 cycles → output `DIV_MUTE`/0 during the pause, then the remaining 6 sounding cycles of BEEP.
6. `rst` asserted mid-PLAY and asynchronously → outputs return to `DIV_MUTE`/0 and `busy`=0 without waiting for a clock edge; `flush` during PLAY with pending P1_CP → IDLE, nothing plays afterwards.
